// File: rtl/debug_tx_sequencer_if.sv
// Bundle between the debug command FSM / snapshot bus / UART TX FIFO and the
// transmit sequencer. The sequencer uses the slave modport; the bench drives master.
interface debug_tx_sequencer_if #(
  parameter int unsigned NUM_BYTES = 220
) ();
  logic                   sendSignal;
  logic [NUM_BYTES*8-1:0] snapshot;
  logic                   tx_full;
  logic                   wr_uart;
  logic [7:0]             w_data;
  logic                   dataSent;
  logic                   busy;

  modport master (
    output sendSignal, snapshot, tx_full,
    input  wr_uart, w_data, dataSent, busy
  );

  modport slave (
    input  sendSignal, snapshot, tx_full,
    output wr_uart, w_data, dataSent, busy
  );
endinterface

// File: rtl/debug_tx_sequencer.sv
// Debug transmit sequencer: on sendSignal, captures the pipeline snapshot and
// streams it byte 0 first into the UART TX FIFO, honouring tx_full, then
// completes a four-phase handshake with the command FSM via dataSent.
// Optional feature macro: DEBUG_TX_CHECKSUM_EN appends a two's-complement
// checksum byte so that all frame bytes sum to 0 mod 256.
module debug_tx_sequencer #(
  parameter int unsigned NUM_BYTES = 220
) (
  input  logic                  clock,
  input  logic                  reset,
  debug_tx_sequencer_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);
  localparam int unsigned SEL_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEND,
`ifdef DEBUG_TX_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_BYTES-1:0][7:0]   shadow_q, shadow_d;
  logic                        data_sent_q, data_sent_d;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [7:0]                  csum_q, csum_d;
`endif

  logic                        wr_uart_c;
  logic [7:0]                  w_data_c;
  logic [7:0]                  cur_byte_c;

  // Byte currently addressed in the captured snapshot.
  assign cur_byte_c = shadow_q[SEL_W'(idx_q)];

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      data_sent_q <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      data_sent_q <= data_sent_d;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state, datapath updates and FIFO write strobe.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
`ifdef DEBUG_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    wr_uart_c = 1'b0;
    w_data_c  = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        if (bus.sendSignal) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        shadow_d = bus.snapshot;
        idx_d    = '0;
`ifdef DEBUG_TX_CHECKSUM_EN
        csum_d   = '0;
`endif
        state_d  = S_SEND;
      end
      S_SEND: begin
        wr_uart_c = !bus.tx_full;
        w_data_c  = cur_byte_c;
        if (wr_uart_c) begin
          idx_d  = idx_q + IDX_W'(1);
`ifdef DEBUG_TX_CHECKSUM_EN
          csum_d = csum_q + cur_byte_c;
          if (idx_q == LAST_IDX) state_d = S_CSUM;
`else
          if (idx_q == LAST_IDX) state_d = S_DONE;
`endif
        end
      end
`ifdef DEBUG_TX_CHECKSUM_EN
      S_CSUM: begin
        wr_uart_c = !bus.tx_full;
        w_data_c  = (~csum_q) + 8'd1;
        if (wr_uart_c) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        // Wait for the request to drop so one request yields exactly one frame.
        if (!bus.sendSignal) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // dataSent tracks residency in DONE, registered.
  assign data_sent_d  = (state_d == S_DONE);

  assign bus.wr_uart  = wr_uart_c;
  assign bus.w_data   = w_data_c;
  assign bus.dataSent = data_sent_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Self-checking bench for debug_tx_sequencer (NUM_BYTES=4). Expected frames are
// built from the snapshot bytes (plus checksum when DEBUG_TX_CHECKSUM_EN is set).
module tb_debug_tx_sequencer;

  localparam int unsigned NB = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  debug_tx_sequencer_if #(.NUM_BYTES(NB)) bus ();

  debug_tx_sequencer #(.NUM_BYTES(NB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rx[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one request/handshake and compares the bytes the FIFO received.
  task automatic do_frame(input string name, input logic [31:0] snap, input int full_pct,
                          input int stall_at, input int stall_len, input bit zap,
                          input bit drop_early);
    logic [7:0] exp_q[$];
    int sum = 0;
    int n = 0;
    int first_wr = -1;
    int viol = 0;
    int stall_left = stall_len;
    bit done = 1'b0;
    for (int k = 0; k < int'(NB); k++) begin
      exp_q.push_back(8'((snap >> (8 * k)) & 32'hFF));
      sum += int'((snap >> (8 * k)) & 32'hFF);
    end
`ifdef DEBUG_TX_CHECKSUM_EN
    exp_q.push_back(8'((256 - (sum % 256)) % 256));
`endif
    rx.delete();
    bus.snapshot   = snap;
    bus.sendSignal = 1'b1;
    while (!done && n < 400) begin
      if (stall_at >= 0 && rx.size() == stall_at && stall_left > 0) begin
        bus.tx_full = 1'b1;
        stall_left--;
      end else begin
        bus.tx_full = (full_pct > 0) && ($urandom_range(99) < full_pct);
      end
      if (zap && n == 2) bus.snapshot = '0;
      if (drop_early && n == 3) bus.sendSignal = 1'b0;
      @(negedge clock);
      if (bus.wr_uart) begin
        rx.push_back(bus.w_data);
        if (first_wr < 0) first_wr = n;
      end
      if (bus.wr_uart && (bus.tx_full || bus.dataSent)) viol++;
      if (bus.dataSent) done = 1'b1;
      step();
      n++;
    end
    bus.tx_full = 1'b0;
    check_eq({name, "_dataSent_seen"}, 32'(done), 32'd1);
    check_eq({name, "_no_wr_when_full_or_done"}, 32'(viol), 32'd0);
    if (!drop_early) begin
      step();
      step();
      @(negedge clock);
      check_eq({name, "_dataSent_held"}, 32'(bus.dataSent), 32'd1);
      check_eq({name, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    end
    bus.sendSignal = 1'b0;
    step();
    step();
    @(negedge clock);
    check_eq({name, "_dataSent_dropped"}, 32'(bus.dataSent), 32'd0);
    check_eq({name, "_idle_after"}, 32'(bus.busy), 32'd0);
    step();
    check_eq({name, "_frame_len"}, 32'(rx.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      check_eq($sformatf("%s_byte%0d", name, k),
               (k < rx.size()) ? 32'(rx[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
    end
    if (full_pct == 0 && stall_at < 0)
      check_eq({name, "_first_write_latency"}, 32'(first_wr), 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [31:0] s;

    // Reset held with a pending request: everything quiet.
    reset          = 1'b0;
    bus.sendSignal = 1'b1;
    bus.tx_full    = 1'b0;
    bus.snapshot   = 32'hDDCC_BBAA;
    repeat (3) step();
    @(negedge clock);
    check_eq("rst_wr_uart", 32'(bus.wr_uart), 32'd0);
    check_eq("rst_dataSent", 32'(bus.dataSent), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);

    // Release: first write happens on the 3rd posedge after release.
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_eq("rel_cyc0_wr", 32'(bus.wr_uart), 32'd0);
    @(negedge clock);
    check_eq("rel_cyc1_wr", 32'(bus.wr_uart), 32'd0);
    @(negedge clock);
    check_eq("rel_cyc2_wr", 32'(bus.wr_uart), 32'd1);
    check_eq("rel_cyc2_data", 32'(bus.w_data), 32'hAA);
    @(posedge clock);
    #1;
    reset          = 1'b0;
    bus.sendSignal = 1'b0;
    #1;
    check_eq("rel_abort_wr", 32'(bus.wr_uart), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Directed frames.
    do_frame("basic",  32'hDDCC_BBAA, 0, -1, 0, 1'b0, 1'b0);
    do_frame("bp",     32'hDDCC_BBAA, 0,  2, 5, 1'b0, 1'b0);
    do_frame("zap",    32'hDDCC_BBAA, 0, -1, 0, 1'b1, 1'b0);
    do_frame("drop",   32'hDDCC_BBAA, 0, -1, 0, 1'b0, 1'b1);
    do_frame("csumv",  32'h0403_0201, 0, -1, 0, 1'b0, 1'b0);

    // Mid-frame reset after byte 1 has been accepted.
    rx.delete();
    bus.snapshot   = 32'hDDCC_BBAA;
    bus.sendSignal = 1'b1;
    cnt = 0;
    while (rx.size() < 2 && cnt < 20) begin
      @(negedge clock);
      if (bus.wr_uart) rx.push_back(bus.w_data);
      step();
      cnt++;
    end
    check_eq("mid_rst_reached_byte1", 32'(rx.size()), 32'd2);
    reset          = 1'b0;
    bus.sendSignal = 1'b0;
    #1;
    check_eq("mid_rst_wr_low", 32'(bus.wr_uart), 32'd0);
    check_eq("mid_rst_idle", 32'(bus.busy), 32'd0);
    step();
    reset = 1'b1;
    step();
    do_frame("after_rst", 32'hDDCC_BBAA, 0, -1, 0, 1'b0, 1'b0);

    // Randomized frames with random backpressure.
    for (int i = 0; i < 10; i++) begin
      s = $urandom();
      do_frame($sformatf("rnd%0d", i), s, int'($urandom_range(60)), -1, 0,
               1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
